// File: rtl/hazard_if.sv
// ID-stage hazard bundle: operand/destination info in, pipeline enables out.
interface hazard_if;
  logic [4:0] IF_ID_rs1;
  logic [4:0] IF_ID_rs2;
  logic       IF_ID_use_rs2;
  logic       branch;
  logic       branch_taken;
  logic [4:0] ID_EX_rd;
  logic       ID_EX_mem_read;
  logic [4:0] EX_MEM_rd;
  logic       EX_MEM_mem_read;
  logic       mem_stall;
  logic       pc_write;
  logic       IF_ID_write;
  logic       IF_ID_flush;
  logic       ID_EX_bubble;
  logic       pipe_hold;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs2, branch, branch_taken,
           ID_EX_rd, ID_EX_mem_read, EX_MEM_rd, EX_MEM_mem_read, mem_stall,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs2, branch, branch_taken,
           ID_EX_rd, ID_EX_mem_read, EX_MEM_rd, EX_MEM_mem_read, mem_stall,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_hold
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall/flush controller for hazards forwarding cannot cover:
// load-use, branch-on-inflight-load, and taken-branch redirect.
module hazard_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_if.slave          hz,
  output logic [CNT_W-1:0] hazard_stall_cnt,
  output logic [CNT_W-1:0] branch_flush_cnt
);

  localparam logic [0:0] RUN        = 1'b0;
  localparam logic [0:0] STALL_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] hs_cnt_q, hs_cnt_d;
  logic [CNT_W-1:0] bf_cnt_q, bf_cnt_d;

  logic mrs1, mrs2, lu, blm, stall_req;
  logic stall, flush;

  always_comb begin
    mrs1 = (hz.IF_ID_rs1 == hz.ID_EX_rd);
    mrs2 = (hz.IF_ID_rs2 == hz.ID_EX_rd);
    lu   = hz.ID_EX_mem_read && (hz.ID_EX_rd != 5'd0) &&
           (mrs1 || ((hz.IF_ID_use_rs2 || hz.branch) && mrs2));
    // A branch compares in ID, so a load one stage further out still blocks it.
    blm  = hz.branch && hz.EX_MEM_mem_read && (hz.EX_MEM_rd != 5'd0) &&
           ((hz.EX_MEM_rd == hz.IF_ID_rs1) || (hz.EX_MEM_rd == hz.IF_ID_rs2));
    stall_req = lu || blm;
    stall = (state_q == STALL_HOLD) || stall_req;
    flush = (state_q == RUN) && !stall_req && hz.branch && hz.branch_taken;
  end

  always_comb begin
    state_d  = state_q;
    hs_cnt_d = hs_cnt_q;
    bf_cnt_d = bf_cnt_q;
    if (!hz.mem_stall) begin
      if (state_q == RUN && hz.branch && lu) state_d = STALL_HOLD;
      else                                   state_d = RUN;
      if (stall) hs_cnt_d = hs_cnt_q + 1'b1;
      if (flush) bf_cnt_d = bf_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      hs_cnt_q <= '0;
      bf_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hs_cnt_q <= hs_cnt_d;
      bf_cnt_q <= bf_cnt_d;
    end
  end

  // Priority: reset, then memory freeze, then hazard stall, then redirect.
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.IF_ID_write  = 1'b1;
    hz.IF_ID_flush  = 1'b0;
    hz.ID_EX_bubble = 1'b0;
    hz.pipe_hold    = 1'b0;
    if (rst) begin
      hz.pc_write     = 1'b0;
      hz.IF_ID_write  = 1'b0;
      hz.IF_ID_flush  = 1'b1;
      hz.ID_EX_bubble = 1'b1;
    end else if (hz.mem_stall) begin
      hz.pipe_hold   = 1'b1;
      hz.pc_write    = 1'b0;
      hz.IF_ID_write = 1'b0;
    end else if (stall) begin
      hz.pc_write     = 1'b0;
      hz.IF_ID_write  = 1'b0;
      hz.ID_EX_bubble = 1'b1;
    end else if (flush) begin
      hz.IF_ID_flush = 1'b1;
    end
  end

  assign hazard_stall_cnt = hs_cnt_q;
  assign branch_flush_cnt = bf_cnt_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall/flush controller in the ID stage of the 5-stage RISC-V pipeline.
- Works alongside the forwarding unit. It covers the hazards forwarding cannot resolve:
  - load-use;
  - a branch in ID that depends on a load still in flight;
  - a taken-branch redirect, which flushes IF/ID.
- Drives the PC and IF/ID write enables, the ID/EX bubble insert, a global hold, and two performance counters.

Parameters:
- CNT_W, 32, width of both performance counters; counters wrap modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- IF_ID_rs1  input  5  rs1 of the instruction in ID.
- IF_ID_rs2  input  5  rs2 of the instruction in ID.
- IF_ID_use_rs2  input  1  instruction in ID reads rs2 (R/S/B type).
- branch  input  1  instruction in ID is a conditional branch; it always reads rs1 and rs2.
- branch_taken  input  1  ID-stage comparator result; valid only when branch=1.
- ID_EX_rd  input  5  destination of the instruction in EX.
- ID_EX_mem_read  input  1  instruction in EX is a load.
- EX_MEM_rd  input  5  destination of the instruction in MEM.
- EX_MEM_mem_read  input  1  instruction in MEM is a load.
- mem_stall  input  1  data memory not ready; freezes the whole pipeline.
- pc_write  output  1  PC update enable.
- IF_ID_write  output  1  IF/ID register load enable.
- IF_ID_flush  output  1  clear IF/ID to NOP on the next edge.
- ID_EX_bubble  output  1  load NOP (control bits zero) into ID/EX on the next edge.
- pipe_hold  output  1  hold ID/EX, EX/MEM and MEM/WB.
- hazard_stall_cnt  output  CNT_W  number of hazard stall cycles.
- branch_flush_cnt  output  CNT_W  number of taken-branch flushes.

Behaviour:
- Combinational hazard terms:
  - mrs1 = (IF_ID_rs1 == ID_EX_rd); mrs2 = (IF_ID_rs2 == ID_EX_rd).
  - LU = ID_EX_mem_read && ID_EX_rd != 0 && (mrs1 || ((IF_ID_use_rs2 || branch) && mrs2)).
  - BLM = branch && EX_MEM_mem_read && EX_MEM_rd != 0 && (EX_MEM_rd == IF_ID_rs1 || EX_MEM_rd == IF_ID_rs2).
  - A branch depending on a non-load in EX or MEM causes no stall; it is handled by forwarding.
- FSM states: RUN, STALL_HOLD.
- RUN:
  - stall_req = LU || BLM.
  - If branch && LU: stall this cycle, next state = STALL_HOLD (2-cycle load-to-branch penalty).
  - Else if stall_req: stall this cycle, next state = RUN.
  - Else: no stall.
- STALL_HOLD: stall unconditionally this cycle, then next state = RUN.
- Stall cycle outputs: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0.
- Taken-branch flush:
  - Fires only in RUN with no stall this cycle, branch=1 and branch_taken=1.
  - Outputs: IF_ID_flush=1, pc_write=1, IF_ID_write=1, ID_EX_bubble=0.
  - Penalty is 1 cycle.
- branch_taken is ignored during any stall cycle, because the operands are not yet valid.
- Normal cycle outputs: pc_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0, pipe_hold=0.
- mem_stall=1 has highest priority:
  - Outputs: pipe_hold=1, pc_write=0, IF_ID_write=0, ID_EX_bubble=0, IF_ID_flush=0.
  - FSM state and both counters hold.
  - A pending STALL_HOLD resumes after mem_stall drops.
- Counters:
  - hazard_stall_cnt increments by 1 on each stall cycle (RUN with stall_req, or STALL_HOLD) when mem_stall=0.
  - branch_flush_cnt increments on each flush cycle.
  - Both wrap from all-ones to 0.
- Output timing: outputs are combinational from state and inputs. Counters are registered and update on the edge that ends the counted cycle.
- Reset:
  - While rst=1: state <= RUN, both counters <= 0.
  - Outputs forced to pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_bubble=1, pipe_hold=0.
  - Reset during STALL_HOLD discards the pending stall; the first cycle after reset is RUN.
- rd == x0 never causes a stall.

Test Plan:
- Load-use:
  - Stimulus: ID_EX_mem_read=1, ID_EX_rd=5, IF_ID_rs1=5, branch=0.
  - Response: exactly 1 cycle of pc_write=0 / ID_EX_bubble=1; hazard_stall_cnt 0->1.
  - Repeat with rd=0: no stall.
- rs2 gating:
  - Stimulus: ID_EX_rd=7 load, IF_ID_rs2=7, IF_ID_use_rs2=0 (I-type).
  - Response: no stall. With use_rs2=1: 1-cycle stall.
- Load-to-branch:
  - Stimulus: branch=1, IF_ID_rs2=9, ID_EX load to rd=9.
  - Response: 2 consecutive stall cycles (RUN then STALL_HOLD), counter +2.
  - A branch_taken=1 held throughout is ignored until the third cycle, which flushes.
- Taken branch with ALU dependency:
  - Stimulus: branch=1, branch_taken=1, ID_EX_reg_write non-load to rd=3, IF_ID_rs1=3.
  - Response: no stall, IF_ID_flush=1 for 1 cycle, branch_flush_cnt=1.
- mem_stall during STALL_HOLD:
  - Stimulus: mem_stall=1 for 3 cycles.
  - Response: pipe_hold=1, state and counters frozen; one remaining stall cycle follows after release.
- Reset and wrap:
  - Assert rst in STALL_HOLD: outputs match the reset values and the next cycle is a normal RUN.
  - With CNT_W=4: 16 stalls wrap hazard_stall_cnt to 0.
